// File: rtl/decoder_arm_ldm_seq.sv
// Block-transfer (LDM/STM) micro-op sequencer: expands one register-list
// instruction into per-register address/register micro-ops plus base writeback.
module decoder_arm_ldm_seq #(
  parameter int unsigned NREG = 16,
  parameter int unsigned AW   = 32,
  parameter int unsigned WB   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    cond_pass,
  input  logic [NREG-1:0]         rlist,
  input  logic [$clog2(NREG)-1:0] rn_id,
  input  logic [AW-1:0]           base,
  input  logic                    ldm_p,
  input  logic                    ldm_u,
  input  logic                    ldm_w,
  input  logic                    ldm_l,
  input  logic                    stall,
  output logic                    ready,
  output logic                    uop_valid,
  output logic [AW-1:0]           uop_addr,
  output logic [$clog2(NREG)-1:0] uop_reg,
  output logic                    uop_load,
  output logic                    uop_last,
  output logic                    done,
  output logic                    wb_en,
  output logic [$clog2(NREG)-1:0] wb_id,
  output logic [AW-1:0]           wb_data
);

  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned CW = $clog2(NREG + 1);

  typedef enum logic [1:0] {IDLE, XFER, FIN} state_e;

  function automatic logic [RW-1:0] lowest_idx(input logic [NREG-1:0] v);
    lowest_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = RW'(i);
    end
  endfunction

  function automatic logic [CW-1:0] count_ones(input logic [NREG-1:0] v);
    count_ones = '0;
    for (int i = 0; i < NREG; i++) begin
      count_ones = count_ones + CW'(v[i]);
    end
  endfunction

  state_e          state_q, state_d;
  logic [NREG-1:0] rem_q, rem_d;
  logic            noop_q, noop_d;
  logic            wbc_q, wbc_d;
  logic            ready_q, ready_d;
  logic            uop_valid_q, uop_valid_d;
  logic [AW-1:0]   uop_addr_q, uop_addr_d;
  logic [RW-1:0]   uop_reg_q, uop_reg_d;
  logic            uop_load_q, uop_load_d;
  logic            uop_last_q, uop_last_d;
  logic            done_q, done_d;
  logic            wb_en_q, wb_en_d;
  logic [RW-1:0]   wb_id_q, wb_id_d;
  logic [AW-1:0]   wb_data_q, wb_data_d;

  logic [CW-1:0]   n_c;
  logic [AW-1:0]   span_c;
  logic [AW-1:0]   start_addr_c;
  logic            exec_c;

  // Instruction decode of the incoming request (only consumed in IDLE)
  always_comb begin
    n_c    = count_ones(rlist);
    span_c = AW'(WB) * AW'(n_c);
    exec_c = cond_pass && (n_c != '0);
    unique case ({ldm_p, ldm_u})
      2'b01:   start_addr_c = base;
      2'b11:   start_addr_c = base + AW'(WB);
      2'b00:   start_addr_c = base - span_c + AW'(WB);
      default: start_addr_c = base - span_c;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    noop_d     = noop_q;
    wbc_d      = wbc_q;
    uop_addr_d = uop_addr_q;
    uop_load_d = uop_load_q;
    wb_id_d    = wb_id_q;
    wb_data_d  = wb_data_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          uop_load_d = ldm_l;
          wb_id_d    = rn_id;
          wb_data_d  = ldm_u ? (base + span_c) : (base - span_c);
          wbc_d      = ldm_w && exec_c && !(ldm_l && rlist[rn_id]);
          if (exec_c) begin
            state_d    = XFER;
            rem_d      = rlist;
            uop_addr_d = start_addr_c;
          end else begin
            // No-op path spends an extra FIN cycle so done lands 2 cycles after start
            state_d = FIN;
            rem_d   = '0;
            noop_d  = 1'b1;
          end
        end
      end
      XFER: begin
        if (!stall) begin
          rem_d      = rem_q & (rem_q - NREG'(1));
          uop_addr_d = uop_addr_q + AW'(WB);
          if (uop_last_q) state_d = FIN;
        end
      end
      FIN: begin
        if (noop_q) noop_d = 1'b0;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d     = (state_d == IDLE);
    uop_valid_d = (state_d == XFER);
    uop_reg_d   = lowest_idx(rem_d);
    uop_last_d  = (state_d == XFER) && ((rem_d & (rem_d - NREG'(1))) == '0);
    done_d      = (state_d == FIN) && !noop_d;
    wb_en_d     = done_d && wbc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      noop_q      <= 1'b0;
      wbc_q       <= 1'b0;
      ready_q     <= 1'b1;
      uop_valid_q <= 1'b0;
      uop_addr_q  <= '0;
      uop_reg_q   <= '0;
      uop_load_q  <= 1'b0;
      uop_last_q  <= 1'b0;
      done_q      <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_id_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      noop_q      <= noop_d;
      wbc_q       <= wbc_d;
      ready_q     <= ready_d;
      uop_valid_q <= uop_valid_d;
      uop_addr_q  <= uop_addr_d;
      uop_reg_q   <= uop_reg_d;
      uop_load_q  <= uop_load_d;
      uop_last_q  <= uop_last_d;
      done_q      <= done_d;
      wb_en_q     <= wb_en_d;
      wb_id_q     <= wb_id_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign ready     = ready_q;
  assign uop_valid = uop_valid_q;
  assign uop_addr  = uop_addr_q;
  assign uop_reg   = uop_reg_q;
  assign uop_load  = uop_load_q;
  assign uop_last  = uop_last_q;
  assign done      = done_q;
  assign wb_en     = wb_en_q;
  assign wb_id     = wb_id_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_decoder_arm_ldm_seq.sv
// Directed bench for decoder_arm_ldm_seq: LDM/STM addressing modes, stall,
// no-op, base-in-list and mid-transfer reset.
module tb_decoder_arm_ldm_seq;

  logic        clk = 1'b0;
  logic        rst, start, cond_pass, stall;
  logic [15:0] rlist;
  logic [3:0]  rn_id;
  logic [31:0] base;
  logic        ldm_p, ldm_u, ldm_w, ldm_l;
  logic        ready, uop_valid, uop_load, uop_last, done, wb_en;
  logic [31:0] uop_addr, wb_data;
  logic [3:0]  uop_reg, wb_id;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decoder_arm_ldm_seq #(.NREG(16), .AW(32), .WB(4)) dut (
    .clk(clk), .rst(rst), .start(start), .cond_pass(cond_pass),
    .rlist(rlist), .rn_id(rn_id), .base(base),
    .ldm_p(ldm_p), .ldm_u(ldm_u), .ldm_w(ldm_w), .ldm_l(ldm_l),
    .stall(stall), .ready(ready), .uop_valid(uop_valid),
    .uop_addr(uop_addr), .uop_reg(uop_reg), .uop_load(uop_load),
    .uop_last(uop_last), .done(done), .wb_en(wb_en),
    .wb_id(wb_id), .wb_data(wb_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_uop(input string t, input logic [31:0] a, input logic [3:0] r,
                         input logic ld, input logic last);
    chk({t, ".valid"}, 64'(uop_valid), 64'(1'b1));
    chk({t, ".addr"},  64'(uop_addr),  64'(a));
    chk({t, ".reg"},   64'(uop_reg),   64'(r));
    chk({t, ".load"},  64'(uop_load),  64'(ld));
    chk({t, ".last"},  64'(uop_last),  64'(last));
    chk({t, ".done"},  64'(done),      64'(1'b0));
    chk({t, ".ready"}, 64'(ready),     64'(1'b0));
  endtask

  task automatic exp_done(input string t, input logic en, input logic [3:0] id,
                          input logic [31:0] d);
    chk({t, ".valid"}, 64'(uop_valid), 64'(1'b0));
    chk({t, ".done"},  64'(done),      64'(1'b1));
    chk({t, ".wb_en"}, 64'(wb_en),     64'(en));
    chk({t, ".wb_id"}, 64'(wb_id),     64'(id));
    chk({t, ".wb_data"}, 64'(wb_data), 64'(d));
  endtask

  task automatic issue(input logic [15:0] rl, input logic [3:0] rn, input logic [31:0] b,
                       input logic p, input logic u, input logic w, input logic l,
                       input logic cp);
    rlist = rl; rn_id = rn; base = b;
    ldm_p = p; ldm_u = u; ldm_w = w; ldm_l = l; cond_pass = cp;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cond_pass = 1'b1; stall = 1'b0;
    rlist = '0; rn_id = '0; base = '0;
    ldm_p = 1'b0; ldm_u = 1'b0; ldm_w = 1'b0; ldm_l = 1'b0;
    step(); step();
    chk("rst.ready",   64'(ready),     64'(1'b1));
    chk("rst.valid",   64'(uop_valid), 64'(1'b0));
    chk("rst.done",    64'(done),      64'(1'b0));
    chk("rst.wb_en",   64'(wb_en),     64'(1'b0));
    chk("rst.addr",    64'(uop_addr),  64'(0));
    chk("rst.wb_data", 64'(wb_data),   64'(0));
    rst = 1'b0;
    step();

    // LDMIA r0!,{r1,r3,r5}
    issue(16'h002A, 4'd0, 32'h1000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    exp_uop("ia.u0", 32'h1000, 4'd1, 1'b1, 1'b0); step();
    exp_uop("ia.u1", 32'h1004, 4'd3, 1'b1, 1'b0); step();
    exp_uop("ia.u2", 32'h1008, 4'd5, 1'b1, 1'b1); step();
    exp_done("ia.fin", 1'b1, 4'd0, 32'h100C); step();
    chk("ia.idle.ready", 64'(ready), 64'(1'b1));
    chk("ia.idle.done",  64'(done),  64'(1'b0));

    // STMDB r13!,{r4-r7,r14}
    issue(16'h40F0, 4'd13, 32'h2000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    exp_uop("db.u0", 32'h1FEC, 4'd4, 1'b0, 1'b0); step();
    exp_uop("db.u1", 32'h1FF0, 4'd5, 1'b0, 1'b0); step();
    exp_uop("db.u2", 32'h1FF4, 4'd6, 1'b0, 1'b0); step();
    exp_uop("db.u3", 32'h1FF8, 4'd7, 1'b0, 1'b0); step();
    exp_uop("db.u4", 32'h1FFC, 4'd14, 1'b0, 1'b1); step();
    exp_done("db.fin", 1'b1, 4'd13, 32'h1FEC); step();

    // LDMIB r1,{r0,r2,r7}, stall 2 cycles on second uop, stray start while busy
    issue(16'h0085, 4'd1, 32'h3000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_uop("ib.u0", 32'h3004, 4'd0, 1'b1, 1'b0); step();
    exp_uop("ib.u1a", 32'h3008, 4'd2, 1'b1, 1'b0);
    stall = 1'b1; step();
    exp_uop("ib.u1b", 32'h3008, 4'd2, 1'b1, 1'b0);
    rlist = 16'hFFFF; base = 32'hDEAD0000; ldm_l = 1'b0; start = 1'b1;
    step();
    start = 1'b0; stall = 1'b0;
    exp_uop("ib.u1c", 32'h3008, 4'd2, 1'b1, 1'b0); step();
    exp_uop("ib.u2", 32'h300C, 4'd7, 1'b1, 1'b1); step();
    exp_done("ib.fin", 1'b0, 4'd1, 32'h300C); step();
    chk("ib.idle.ready", 64'(ready), 64'(1'b1));

    // cond_pass=0: no micro-ops, done on cycle 2
    issue(16'h0003, 4'd5, 32'h8000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("cp0.c1.valid", 64'(uop_valid), 64'(1'b0));
    chk("cp0.c1.done",  64'(done),      64'(1'b0));
    chk("cp0.c1.ready", 64'(ready),     64'(1'b0));
    step();
    exp_done("cp0.fin", 1'b0, 4'd5, 32'h8008); step();
    chk("cp0.idle.ready", 64'(ready), 64'(1'b1));

    // empty register list
    issue(16'h0000, 4'd6, 32'h9000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("empty.c1.valid", 64'(uop_valid), 64'(1'b0));
    chk("empty.c1.done",  64'(done),      64'(1'b0));
    step();
    exp_done("empty.fin", 1'b0, 4'd6, 32'h9000); step();

    // LDMIA r2!,{r2,r4}: loaded base suppresses writeback
    issue(16'h0014, 4'd2, 32'h4000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    exp_uop("rnl.u0", 32'h4000, 4'd2, 1'b1, 1'b0); step();
    exp_uop("rnl.u1", 32'h4004, 4'd4, 1'b1, 1'b1); step();
    exp_done("rnl.fin", 1'b0, 4'd2, 32'h4008); step();

    // LDMDA r9!,{r3,r8}
    issue(16'h0108, 4'd9, 32'h5000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    exp_uop("da.u0", 32'h4FFC, 4'd3, 1'b1, 1'b0); step();
    exp_uop("da.u1", 32'h5000, 4'd8, 1'b1, 1'b1); step();
    exp_done("da.fin", 1'b1, 4'd9, 32'h4FF8); step();

    // reset on cycle 2 of a 4-register transfer, then immediate new start
    issue(16'h000F, 4'd12, 32'h6000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    exp_uop("rs.u0", 32'h6000, 4'd0, 1'b1, 1'b0); step();
    exp_uop("rs.u1", 32'h6004, 4'd1, 1'b1, 1'b0);
    rst = 1'b1; step();
    chk("rs.valid", 64'(uop_valid), 64'(1'b0));
    chk("rs.ready", 64'(ready),     64'(1'b1));
    chk("rs.done",  64'(done),      64'(1'b0));
    chk("rs.wb_en", 64'(wb_en),     64'(1'b0));
    rst = 1'b0;
    issue(16'h0001, 4'd3, 32'h7000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_uop("rs2.u0", 32'h7000, 4'd0, 1'b0, 1'b1); step();
    exp_done("rs2.fin", 1'b0, 4'd3, 32'h7004); step();
    chk("rs2.idle.ready", 64'(ready), 64'(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
